// File: rtl/upsp_frame_ctrl_if.sv
// Stream-monitor and frame-strobe bundle between the frame sequencer and the
// input path it observes / drives.
interface upsp_frame_ctrl_if;
    logic mon_tvalid;
    logic mon_tready;
    logic mon_tlast;
    logic upsp_done;
    logic upstart;
    logic upend;

    // Environment side: presents the observed stream and engine completion.
    modport master (
        output mon_tvalid,
        output mon_tready,
        output mon_tlast,
        output upsp_done,
        input  upstart,
        input  upend
    );

    // Sequencer side: observes the stream, issues frame strobes.
    modport slave (
        input  mon_tvalid,
        input  mon_tready,
        input  mon_tlast,
        input  upsp_done,
        output upstart,
        output upend
    );
endinterface

// File: rtl/upsp_frame_ctrl.sv
// Frame sequencer for the super-resolution input stream: issues UPSTART,
// counts row-end handshakes, waits for the Up-Sampling engine to finish and
// issues UPEND. Supports continuous mode, abort, stall timeout, sticky error
// flags and a clean-frame counter.
module upsp_frame_ctrl #(
    parameter int unsigned SRC_IMG_HEIGHT  = 2160,
    parameter int unsigned TIMEOUT_CYCLES  = 1048576,
    parameter int unsigned FRAME_CNT_WIDTH = 16,
    localparam int unsigned ROW_W          = $clog2(SRC_IMG_HEIGHT + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_start,
    input  logic                       cfg_continuous,
    input  logic                       cfg_abort,
    upsp_frame_ctrl_if.slave           bus,
    output logic                       busy,
    output logic [ROW_W-1:0]           row_cnt,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
    output logic                       err_timeout,
    output logic                       err_short,
    output logic                       err_abort
);

    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [ROW_W-1:0] LAST_ROW_IDX = ROW_W'(SRC_IMG_HEIGHT - 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT    = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DRAIN,
        S_END
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;

    logic row_hs;
    logic last_row_hs;
    logic progress;
    logic stalled;
    logic any_err;

    // Decode of the monitored stream and the stall/err conditions.
    assign row_hs      = bus.mon_tvalid & bus.mon_tready & bus.mon_tlast;
    assign last_row_hs = row_hs & (row_cnt == LAST_ROW_IDX);
    assign progress    = row_hs | bus.upsp_done;
    assign stalled     = (timer == TMR_LIMIT);
    assign any_err     = err_timeout | err_short | err_abort;

    // Frame sequencer: state, counters, strobes and sticky flags.
    // Abort preempts everything, including the row count of that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            bus.upstart <= 1'b0;
            bus.upend   <= 1'b0;
            busy        <= 1'b0;
            row_cnt     <= '0;
            frame_cnt   <= '0;
            err_timeout <= 1'b0;
            err_short   <= 1'b0;
            err_abort   <= 1'b0;
        end else begin
            bus.upstart <= 1'b0;
            bus.upend   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        err_timeout <= 1'b0;
                        err_short   <= 1'b0;
                        err_abort   <= 1'b0;
                        bus.upstart <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_START;
                    end
                end

                S_START: begin
                    row_cnt <= '0;
                    timer   <= '0;
                    if (cfg_abort) begin
                        err_abort <= 1'b1;
                        bus.upend <= 1'b1;
                        state     <= S_END;
                    end else begin
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (cfg_abort) begin
                        err_abort <= 1'b1;
                        bus.upend <= 1'b1;
                        state     <= S_END;
                    end else if (stalled) begin
                        err_timeout <= 1'b1;
                        bus.upend   <= 1'b1;
                        state       <= S_END;
                    end else begin
                        if (row_hs) begin
                            row_cnt <= row_cnt + ROW_W'(1);
                        end
                        timer <= progress ? '0 : timer + TMR_W'(1);
                        if (last_row_hs) begin
                            if (bus.upsp_done) begin
                                bus.upend <= 1'b1;
                                state     <= S_END;
                            end else begin
                                state <= S_DRAIN;
                            end
                        end else if (bus.upsp_done) begin
                            err_short <= 1'b1;
                            bus.upend <= 1'b1;
                            state     <= S_END;
                        end
                    end
                end

                S_DRAIN: begin
                    if (cfg_abort) begin
                        err_abort <= 1'b1;
                        bus.upend <= 1'b1;
                        state     <= S_END;
                    end else if (stalled) begin
                        err_timeout <= 1'b1;
                        bus.upend   <= 1'b1;
                        state       <= S_END;
                    end else begin
                        timer <= progress ? '0 : timer + TMR_W'(1);
                        if (bus.upsp_done) begin
                            bus.upend <= 1'b1;
                            state     <= S_END;
                        end
                    end
                end

                S_END: begin
                    if (!any_err) begin
                        frame_cnt <= frame_cnt + FRAME_CNT_WIDTH'(1);
                    end
                    if (cfg_continuous && !any_err) begin
                        bus.upstart <= 1'b1;
                        state       <= S_START;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upsp_frame_ctrl.sv
// Scoreboard bench for upsp_frame_ctrl (4-row frames, 16-cycle timeout).
module tb_upsp_frame_ctrl;

    localparam int unsigned H  = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned FW = 16;
    localparam int unsigned RW = $clog2(H + 1);

    typedef struct {
        int          cyc;      // interval in which upend must appear
        logic [2:0]  err;      // {timeout, short, abort} during upend
        int          row;      // row_cnt during upend, -1 = don't care
        logic [15:0] fc;       // frame_cnt the cycle after upend
        logic        restart;  // upstart/busy the cycle after upend
    } exp_t;

    logic          clk;
    logic          rst;
    logic          cfg_start;
    logic          cfg_continuous;
    logic          cfg_abort;
    logic          busy;
    logic [RW-1:0] row_cnt;
    logic [FW-1:0] frame_cnt;
    logic          err_timeout;
    logic          err_short;
    logic          err_abort;

    upsp_frame_ctrl_if bus ();

    upsp_frame_ctrl #(
        .SRC_IMG_HEIGHT (H),
        .TIMEOUT_CYCLES (TO),
        .FRAME_CNT_WIDTH(FW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_continuous(cfg_continuous),
        .cfg_abort     (cfg_abort),
        .bus           (bus),
        .busy          (busy),
        .row_cnt       (row_cnt),
        .frame_cnt     (frame_cnt),
        .err_timeout   (err_timeout),
        .err_short     (err_short),
        .err_abort     (err_abort)
    );

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_starts = 0;
    int   n_exp_starts = 0;
    exp_t q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic row();
        bus.mon_tvalid = 1'b1;
        bus.mon_tready = 1'b1;
        bus.mon_tlast  = 1'b1;
        tick();
        bus.mon_tvalid = 1'b0;
        bus.mon_tready = 1'b0;
        bus.mon_tlast  = 1'b0;
    endtask

    task automatic beat(input logic rdy, input logic last);
        bus.mon_tvalid = 1'b1;
        bus.mon_tready = rdy;
        bus.mon_tlast  = last;
        tick();
        bus.mon_tvalid = 1'b0;
        bus.mon_tready = 1'b0;
        bus.mon_tlast  = 1'b0;
    endtask

    task automatic done();
        bus.upsp_done = 1'b1;
        tick();
        bus.upsp_done = 1'b0;
    endtask

    task automatic expect_end(input int dly, input logic [2:0] err, input int r,
                              input logic [15:0] fc, input logic restart);
        exp_t e;
        e.cyc = cyc + dly;
        e.err = err;
        e.row = r;
        e.fc = fc;
        e.restart = restart;
        q.push_back(e);
    endtask

    // Pulse cfg_start in IDLE; returns in the first RUN interval.
    task automatic do_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        n_exp_starts++;
        chk("start_upstart", 32'(bus.upstart), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_err_clear", 32'({err_timeout, err_short, err_abort}), 0);
        tick();
    endtask

    task automatic reset_dut(input string name);
        rst = 1'b1;
        idle(2);
        chk({name, "_upstart"}, 32'(bus.upstart), 0);
        chk({name, "_upend"}, 32'(bus.upend), 0);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_row_cnt"}, 32'(row_cnt), 0);
        chk({name, "_frame_cnt"}, 32'(frame_cnt), 0);
        chk({name, "_err"}, 32'({err_timeout, err_short, err_abort}), 0);
        rst = 1'b0;
        tick();
    endtask

    // Monitor: pops an expectation on every upend, checks follow-up next cycle.
    initial begin
        exp_t pend;
        logic post = 1'b0;
        forever begin
            @(negedge clk);
            if (post) begin
                chk("post_frame_cnt", 32'(frame_cnt), 32'(pend.fc));
                chk("post_upstart", 32'(bus.upstart), 32'(pend.restart));
                chk("post_busy", 32'(busy), 32'(pend.restart));
                post = 1'b0;
            end
            if (bus.upstart === 1'b1) n_starts++;
            if (bus.upend === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_upend: got upend=1 expected none (cycle %0d)", cyc);
                end else begin
                    pend = q.pop_front();
                    chk("upend_cycle", 32'(cyc), 32'(pend.cyc));
                    chk("upend_err", 32'({err_timeout, err_short, err_abort}), 32'(pend.err));
                    if (pend.row >= 0) chk("upend_row_cnt", 32'(row_cnt), 32'(pend.row));
                    post = 1'b1;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        cfg_start      = 1'b0;
        cfg_continuous = 1'b0;
        cfg_abort      = 1'b0;
        bus.mon_tvalid = 1'b0;
        bus.mon_tready = 1'b0;
        bus.mon_tlast  = 1'b0;
        bus.upsp_done  = 1'b0;

        // Single shot with non-row beats and an extra row in DRAIN.
        reset_dut("reset");
        do_start();
        row();
        beat(1'b1, 1'b0);
        row();
        row();
        beat(1'b0, 1'b1);
        row();
        chk("drain_row_cnt", 32'(row_cnt), 4);
        chk("drain_busy", 32'(busy), 1);
        row();
        chk("drain_extra_row", 32'(row_cnt), 4);
        idle(1);
        expect_end(1, 3'b000, 4, 16'd1, 1'b0);
        done();
        idle(4);

        // Continuous: three frames, continuous dropped during the third.
        reset_dut("reset2");
        cfg_continuous = 1'b1;
        do_start();
        for (int f = 0; f < 3; f++) begin
            if (f == 2) cfg_continuous = 1'b0;
            for (int r = 0; r < 4; r++) row();
            idle(2);
            expect_end(1, 3'b000, 4, 16'(f + 1), (f < 2));
            done();
            if (f < 2) begin
                n_exp_starts++;
                idle(2);
            end
        end
        idle(3);
        chk("cont_frame_cnt", 32'(frame_cnt), 3);

        // Short frame stops continuous mode.
        cfg_continuous = 1'b1;
        do_start();
        row();
        row();
        idle(1);
        expect_end(1, 3'b010, 2, 16'd3, 1'b0);
        done();
        idle(3);
        cfg_continuous = 1'b0;

        // Timeout after one row; tready toggling / tlast without tready.
        do_start();
        row();
        expect_end(16, 3'b100, 1, 16'd3, 1'b0);
        for (int i = 0; i < 8; i++) beat(1'(i & 1), 1'b0);
        for (int i = 0; i < 2; i++) beat(1'b0, 1'b1);
        idle(10);

        // Abort coincident with final row; cfg_start during RUN ignored.
        do_start();
        row();
        cfg_start = 1'b1;
        row();
        cfg_start = 1'b0;
        chk("run_start_ignored", 32'(bus.upstart), 0);
        row();
        expect_end(1, 3'b001, -1, 16'd3, 1'b0);
        cfg_abort = 1'b1;
        row();
        cfg_abort = 1'b0;
        idle(3);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 0);
        chk("idle_abort_sticky", 32'(err_abort), 1);
        chk("abort_frame_cnt", 32'(frame_cnt), 3);

        // Reset while in DRAIN: everything clears, no upend.
        do_start();
        for (int r = 0; r < 4; r++) row();
        idle(1);
        rst = 1'b1;
        tick();
        chk("drain_rst_upend", 32'(bus.upend), 0);
        chk("drain_rst_busy", 32'(busy), 0);
        chk("drain_rst_row_cnt", 32'(row_cnt), 0);
        chk("drain_rst_frame_cnt", 32'(frame_cnt), 0);
        chk("drain_rst_err", 32'({err_timeout, err_short, err_abort}), 0);
        rst = 1'b0;
        tick();
        done();
        idle(20);

        // Last row and upsp_done in the same cycle: clean completion.
        do_start();
        for (int r = 0; r < 3; r++) row();
        expect_end(1, 3'b000, 4, 16'd1, 1'b0);
        bus.upsp_done = 1'b1;
        row();
        bus.upsp_done = 1'b0;
        idle(4);
        chk("same_cycle_frame_cnt", 32'(frame_cnt), 1);

        chk("pending_expectations", 32'(q.size()), 0);
        chk("upstart_count", 32'(n_starts), 32'(n_exp_starts));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
